// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns engine: COLS_PER_CYCLE columns per clock through a shared column unit.
// Define INV_MIX_COLUMNS_EN to build the InvMixColumns unit selected by mode_inv.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         mode_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int NBEATS = 4 / ((COLS_PER_CYCLE > 0) ? COLS_PER_CYCLE : 1);
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [BEAT_W-1:0]   beat_reg;
    logic [127:0]        work_reg;
    logic                out_valid_reg;
    logic                busy_reg;
    logic                accept;

    logic [1:0]          col_idx [COLS_PER_CYCLE];
    logic [31:0]         col_in  [COLS_PER_CYCLE];
    logic [31:0]         col_out [COLS_PER_CYCLE];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, d3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        return {d0 ^ (d1 ^ a1) ^ a2 ^ a3,
                a0 ^ d1 ^ (d2 ^ a2) ^ a3,
                a0 ^ a1 ^ d2 ^ (d3 ^ a3),
                (d0 ^ a0) ^ a1 ^ a2 ^ d3};
    endfunction

`ifdef INV_MIX_COLUMNS_EN
    logic mode_reg;

    // Multiples 9, b, d, e of one byte, built from x2/x4/x8 chains.
    function automatic logic [31:0] inv_mults(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return {x8 ^ a, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ x4 ^ x2};
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [31:0] m0, m1, m2, m3;
        // each m holds {9a, ba, da, ea}
        m0 = inv_mults(c[31:24]);
        m1 = inv_mults(c[23:16]);
        m2 = inv_mults(c[15:8]);
        m3 = inv_mults(c[7:0]);
        return {m0[7:0]   ^ m1[23:16] ^ m2[15:8]  ^ m3[31:24],
                m0[31:24] ^ m1[7:0]   ^ m2[23:16] ^ m3[15:8],
                m0[15:8]  ^ m1[31:24] ^ m2[7:0]   ^ m3[23:16],
                m0[23:16] ^ m1[15:8]  ^ m2[31:24] ^ m3[7:0]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg <= 1'b0;
        end else if (accept) begin
            mode_reg <= mode_inv;
        end
    end
`else
    logic unused_mode_inv;
    assign unused_mode_inv = mode_inv;
`endif

    generate
        for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_col
            assign col_idx[gi] = 2'(int'(beat_reg) * COLS_PER_CYCLE + gi);
            assign col_in[gi]  = work_reg[{col_idx[gi], 5'b0} +: 32];
`ifdef INV_MIX_COLUMNS_EN
            assign col_out[gi] = mode_reg ? inv_col(col_in[gi]) : fwd_col(col_in[gi]);
`else
            assign col_out[gi] = fwd_col(col_in[gi]);
`endif
        end
    endgenerate

    // A finished result may hand off and take the next block on the same edge.
    assign in_ready  = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign state_out = work_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            beat_reg      <= '0;
            work_reg      <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        work_reg  <= state_in;
                        beat_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        work_reg[{col_idx[i], 5'b0} +: 32] <= col_out[i];
                    end
                    if (beat_reg == LAST_BEAT) begin
                        busy_reg      <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        beat_reg <= beat_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        if (in_valid) begin
                            work_reg  <= state_in;
                            beat_reg  <= '0;
                            busy_reg  <= 1'b1;
                            state_reg <= BUSY;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle) checked against a GF(2^8) matrix model.
module tb_mix_columns_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid_a  [3];
    logic         in_ready_a  [3];
    logic [127:0] state_in_a  [3];
    logic         mode_inv_a  [3];
    logic         out_valid_a [3];
    logic         out_ready_a [3];
    logic [127:0] state_out_a [3];
    logic         busy_a      [3];

    int checks;
    int failures;

`ifdef INV_MIX_COLUMNS_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            mix_columns_seq #(.COLS_PER_CYCLE(1 << gi)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid_a[gi]),
                .in_ready  (in_ready_a[gi]),
                .state_in  (state_in_a[gi]),
                .mode_inv  (mode_inv_a[gi]),
                .out_valid (out_valid_a[gi]),
                .out_ready (out_ready_a[gi]),
                .state_out (state_out_a[gi]),
                .busy      (busy_a[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain GF(2^8) multiply and a circulant coefficient matrix.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [127:0] r;
        if (inv && INV_EN) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[32*c + 31 - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(coef[(k - row + 4) % 4], a[k]);
                r[32*c + 31 - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Waits for out_valid while scrambling inputs that must be ignored.
    task automatic wait_valid(input int idx, output int lat);
        lat = 0;
        while (out_valid_a[idx] !== 1'b1 && lat < 20) begin
            check("in_ready_low_while_busy", in_ready_a[idx], 1'b0);
            in_valid_a[idx] = 1'($urandom);
            mode_inv_a[idx] = 1'($urandom);
            state_in_a[idx] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_reached", out_valid_a[idx], 1'b1);
    endtask

    task automatic handoff(input int idx);
        in_valid_a[idx]  = 1'b0;
        out_ready_a[idx] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[idx] = 1'b0;
        check("out_valid_cleared", out_valid_a[idx], 1'b0);
        check("in_ready_idle", in_ready_a[idx], 1'b1);
    endtask

    task automatic run_block(input int idx, input logic [127:0] din, input logic inv,
                             output logic [127:0] res);
        int lat;
        check("in_ready_before_accept", in_ready_a[idx], 1'b1);
        in_valid_a[idx] = 1'b1;
        state_in_a[idx] = din;
        mode_inv_a[idx] = inv;
        @(posedge clk); #1;
        in_valid_a[idx] = 1'b0;
        check("busy_after_accept", busy_a[idx], 1'b1);
        wait_valid(idx, lat);
        check("latency", 128'(lat), 128'(4 >> idx));
        res = state_out_a[idx];
        $display("blk cpc=%0d mode=%0d in=%h out=%h lat=%0d", 1 << idx, inv, din, res, lat);
        handoff(idx);
    endtask

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    initial begin
        vec_t         vecs [4];
        logic [127:0] res;
        logic [127:0] held;
        logic [127:0] din;
        logic         inv;
        int           lat;

        checks   = 0;
        failures = 0;

        vecs[0].din = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6};
        vecs[0].inv = 1'b0;
        vecs[0].exp = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6};
        vecs[1].din = {32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6};
        vecs[1].inv = 1'b1;
`ifdef INV_MIX_COLUMNS_EN
        vecs[1].exp = {32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5};
`else
        vecs[1].exp = model(vecs[1].din, 1'b0);
`endif
        vecs[2].din = 128'h0;
        vecs[2].inv = 1'b0;
        vecs[2].exp = 128'h0;
        vecs[3].din = {128{1'b1}};
        vecs[3].inv = 1'b1;
        vecs[3].exp = {128{1'b1}};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            out_ready_a[i] = 1'b0;
            mode_inv_a[i]  = 1'b0;
            state_in_a[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_out_valid", out_valid_a[i], 1'b0);
            check("reset_busy", busy_a[i], 1'b0);
            check("reset_state_out", state_out_a[i], 128'h0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) check("in_ready_after_reset", in_ready_a[i], 1'b1);

        // Table vectors on every column width
        for (int i = 0; i < 3; i++) begin
            for (int v = 0; v < 4; v++) begin
                run_block(i, vecs[v].din, vecs[v].inv, res);
                check("table_vector", res, vecs[v].exp);
            end
        end

        // Random blocks against the model
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 12; n++) begin
                din = {$urandom, $urandom, $urandom, $urandom};
                inv = 1'($urandom);
                run_block(i, din, inv, res);
                check("random_block", res, model(din, inv));
            end
        end

        // Backpressure: hold DONE for 10 cycles with ignored in_valid
        din = {$urandom, $urandom, $urandom, $urandom};
        in_valid_a[0] = 1'b1;
        state_in_a[0] = din;
        mode_inv_a[0] = 1'b0;
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        wait_valid(0, lat);
        held = state_out_a[0];
        check("bp_first_result", held, model(din, 1'b0));
        for (int n = 0; n < 10; n++) begin
            in_valid_a[0] = 1'b1;
            state_in_a[0] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check("bp_state_out_stable", state_out_a[0], held);
            check("bp_in_ready_low", in_ready_a[0], 1'b0);
            check("bp_out_valid_held", out_valid_a[0], 1'b1);
        end
        din = {$urandom, $urandom, $urandom, $urandom};
        state_in_a[0]  = din;
        mode_inv_a[0]  = 1'b0;
        in_valid_a[0]  = 1'b1;
        out_ready_a[0] = 1'b1;
        #1;
        check("bp_in_ready_comb", in_ready_a[0], 1'b1);
        @(posedge clk); #1;
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b0;
        check("bp_busy_next", busy_a[0], 1'b1);
        check("bp_out_valid_drop", out_valid_a[0], 1'b0);
        wait_valid(0, lat);
        check("bp_back_to_back_latency", 128'(lat), 128'd4);
        check("bp_second_result", state_out_a[0], model(din, 1'b0));
        $display("blk cpc=1 back-to-back out=%h lat=%0d", state_out_a[0], lat);
        handoff(0);

        // Asynchronous reset during beat 1
        in_valid_a[0] = 1'b1;
        state_in_a[0] = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        in_valid_a[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid_a[0], 1'b0);
        check("async_rst_busy", busy_a[0], 1'b0);
        check("async_rst_state_out", state_out_a[0], 128'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        din = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, din, 1'b1, res);
        check("after_reset_block", res, model(din, 1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
